trng_ro_ctrl: RTL

- Controller for the ring-oscillator entropy source and its sampling flops.
- Sequences RO start-up: enable, warm-up, then sampling.
- Runs the online health tests on every sampled bit: a repetition count test (RCT) and an adaptive proportion test (APT).
- Packs raw bits into words behind a valid/ready interface and shuts the source down on a health alarm.

---
 rtl/trng_ro_ctrl_if.sv | 12 +
 rtl/trng_ro_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/trng_ro_ctrl_if.sv
// Word output channel of the TRNG controller: producer drives data/valid,
// consumer drives ready.
interface trng_ro_ctrl_if #(
  parameter int WORD_W = 32
) ();
  logic [WORD_W-1:0] rnd_data;
  logic              rnd_valid;
  logic              rnd_ready;

  modport master (output rnd_data, output rnd_valid, input rnd_ready);
  modport slave  (input rnd_data, input rnd_valid, output rnd_ready);
endinterface

// File: rtl/trng_ro_ctrl.sv
// Ring-oscillator TRNG controller: start-up sequencing, RCT/APT online health
// tests and LSB-first word packing behind a valid/ready channel.
module trng_ro_ctrl #(
  parameter int WORD_W     = 32,
  parameter int WARMUP_CYC = 16,
  parameter int RCT_WARN   = 8,
  parameter int RCT_CUTOFF = 11,
  parameter int APT_WINDOW = 1024,
  parameter int APT_CUTOFF = 589
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stop,
  input  logic            clear_alarm,
  input  logic            rnd_bit,
  output logic            ro_en,
  output logic            dff_en,
  output logic            rct_warn,
  output logic            alarm_rct,
  output logic            alarm_apt,
  output logic            word_drop,
  output logic            busy,
  trng_ro_ctrl_if.master  rnd_if
);

  localparam int WCW = $clog2(WARMUP_CYC + 1);
  localparam int RLW = $clog2(RCT_CUTOFF + 1);
  localparam int AW  = $clog2(APT_WINDOW + 1);
  localparam int PW  = $clog2(WORD_W);

  localparam logic [WCW-1:0] WARM_LAST = WCW'(WARMUP_CYC - 1);
  localparam logic [RLW-1:0] RL_WARN   = RLW'(RCT_WARN);
  localparam logic [RLW-1:0] RL_CUT    = RLW'(RCT_CUTOFF);
  localparam logic [AW-1:0]  APT_LEN   = AW'(APT_WINDOW);
  localparam logic [AW-1:0]  APT_HI    = AW'(APT_CUTOFF);
  localparam logic [AW-1:0]  APT_LO    = AW'(APT_WINDOW - APT_CUTOFF);
  localparam logic [PW-1:0]  PK_LAST   = PW'(WORD_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_RUN, S_ALARM} state_e;

  state_e             state_q, state_d;
  logic [WCW-1:0]     warm_q, warm_d;
  logic [RLW-1:0]     run_len_q, run_len_d;
  logic               prev_q, prev_d;
  logic [AW-1:0]      ones_q, ones_d;
  logic [AW-1:0]      bits_q, bits_d;
  logic [WORD_W-1:0]  sr_q, sr_d;
  logic [PW-1:0]      pk_q, pk_d;
  logic [WORD_W-1:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               warn_q, warn_d;
  logic               drop_q, drop_d;
  logic               arct_q, arct_d;
  logic               aapt_q, aapt_d;

  logic [RLW-1:0]     run_nxt;
  logic [AW-1:0]      ones_nxt, bits_nxt;
  logic               rct_fail, apt_fail, word_done;

  always_comb begin
    state_d   = state_q;
    warm_d    = warm_q;
    run_len_d = run_len_q;
    prev_d    = prev_q;
    ones_d    = ones_q;
    bits_d    = bits_q;
    sr_d      = sr_q;
    pk_d      = pk_q;
    data_d    = data_q;
    valid_d   = valid_q;
    warn_d    = 1'b0;
    drop_d    = 1'b0;
    arct_d    = arct_q;
    aapt_d    = aapt_q;
    run_nxt   = '0;
    ones_nxt  = '0;
    bits_nxt  = '0;
    rct_fail  = 1'b0;
    apt_fail  = 1'b0;
    word_done = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_WARMUP;
          warm_d  = '0;
        end
      end
      S_WARMUP: begin
        if (stop) begin
          state_d = S_IDLE;
        end else if (warm_q == WARM_LAST) begin
          // Fresh health-test and packing state for every RUN entry.
          state_d   = S_RUN;
          run_len_d = '0;
          prev_d    = 1'b0;
          ones_d    = '0;
          bits_d    = '0;
          sr_d      = '0;
          pk_d      = '0;
        end else begin
          warm_d = warm_q + WCW'(1);
        end
      end
      S_RUN: begin
        // run_len_q==0 marks "no previous bit yet" after entering RUN.
        if (run_len_q != '0 && rnd_bit == prev_q)
          run_nxt = (run_len_q == RL_CUT) ? RL_CUT : run_len_q + RLW'(1);
        else
          run_nxt = RLW'(1);
        run_len_d = run_nxt;
        prev_d    = rnd_bit;
        warn_d    = (run_nxt == RL_WARN);
        rct_fail  = (run_nxt == RL_CUT);

        ones_nxt = ones_q + {{(AW-1){1'b0}}, rnd_bit};
        bits_nxt = bits_q + AW'(1);
        if (bits_nxt == APT_LEN) begin
          apt_fail = (ones_nxt > APT_HI) || (ones_nxt < APT_LO);
          ones_d   = '0;
          bits_d   = '0;
        end else begin
          ones_d = ones_nxt;
          bits_d = bits_nxt;
        end

        sr_d      = {rnd_bit, sr_q[WORD_W-1:1]};
        word_done = (pk_q == PK_LAST);
        pk_d      = word_done ? '0 : pk_q + PW'(1);

        if (valid_q && rnd_if.rnd_ready) valid_d = 1'b0;

        if (rct_fail || apt_fail) begin
          state_d = S_ALARM;
          arct_d  = arct_q | rct_fail;
          aapt_d  = aapt_q | apt_fail;
          valid_d = 1'b0;
        end else if (stop) begin
          state_d = S_IDLE;
          valid_d = 1'b0;
        end else if (word_done) begin
          if (!valid_q || rnd_if.rnd_ready) begin
            data_d  = sr_d;
            valid_d = 1'b1;
          end else begin
            drop_d = 1'b1;
          end
        end
      end
      S_ALARM: begin
        if (clear_alarm) begin
          state_d = S_IDLE;
          arct_d  = 1'b0;
          aapt_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      warm_q    <= '0;
      run_len_q <= '0;
      prev_q    <= 1'b0;
      ones_q    <= '0;
      bits_q    <= '0;
      sr_q      <= '0;
      pk_q      <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      warn_q    <= 1'b0;
      drop_q    <= 1'b0;
      arct_q    <= 1'b0;
      aapt_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      warm_q    <= warm_d;
      run_len_q <= run_len_d;
      prev_q    <= prev_d;
      ones_q    <= ones_d;
      bits_q    <= bits_d;
      sr_q      <= sr_d;
      pk_q      <= pk_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      warn_q    <= warn_d;
      drop_q    <= drop_d;
      arct_q    <= arct_d;
      aapt_q    <= aapt_d;
    end
  end

  assign ro_en            = (state_q == S_WARMUP) || (state_q == S_RUN);
  assign dff_en           = ro_en;
  assign busy             = (state_q != S_IDLE);
  assign rct_warn         = warn_q;
  assign word_drop        = drop_q;
  assign alarm_rct        = arct_q;
  assign alarm_apt        = aapt_q;
  assign rnd_if.rnd_data  = data_q;
  assign rnd_if.rnd_valid = valid_q;

endmodule
